tiny_rv_br_unit: RTL and testbench
==================================

Name: tiny_rv_br_unit

Overview:
Parametrised, pipelined successor to the combinational branch resolver in the execute stage. Resolves JAL, JALR and conditional branches one cycle after a valid/ready handshake and compares the result against the fetch-stage prediction to flag mispredicts. Owns the 2-bit bimodal history table (BHT) and the return-address stack (RAS). Fetch queries both through a combinational predict port.

Parameters:
XLEN, 32, datapath and address width
BHT_ENTRIES, 16, number of 2-bit counters; power of 2, at least 2
RAS_DEPTH, 4, return-address stack entries; at least 1
C_EXT, 0, 1 = 16-bit instruction alignment (target[1] is not checked)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  drop the staged result and any input presented this cycle
i_valid  in  1  request valid
o_ready  out  1  request accepted when i_valid && o_ready
i_pc, i_next_pc, i_offset  in  XLEN each  instruction PC, PC+len, pre-decoded immediate
i_opcode  in  7  major opcode
i_funct3  in  3  branch condition
i_rs1, i_rs2  in  XLEN each  operand values
i_rd_idx, i_rs1_idx  in  5 each  register indices, used for RAS hints
i_pred_taken  in  1  fetch predicted taken
i_pred_addr  in  XLEN  fetch predicted target
o_valid  out  1  result valid
i_ready  in  1  downstream accepts the result
o_br_taken  out  1  control transfer resolved taken
o_br_addr  out  XLEN  resolved target
o_mispredict  out  1  fetch must redirect
o_redirect_addr  out  XLEN  correct next PC
o_misaligned  out  1  instruction-address-misaligned exception
o_active  out  1  result writes rd
o_result  out  XLEN  link value
i_fetch_pc  in  XLEN  predict-port lookup PC
o_fetch_pred_taken  out  1  BHT counter MSB for i_fetch_pc
o_ras_top  out  XLEN  current RAS top
o_ras_valid  out  1  RAS not empty

Behaviour:
- Clocking and reset: single clock i_clk; reset is asynchronous, active-low (i_rst_n).
- Reset values: all registered o_* = 0; BHT counters = 2'b01 (weakly not-taken); RAS count = 0 and entries = 0.
- Handshake:
  - o_ready = !o_valid || i_ready, i.e. a one-deep output register.
  - Latency is exactly 1 cycle from accept to o_valid.
  - Outputs hold stable while o_valid && !i_ready.
- Index: BHT index = pc[$clog2(BHT_ENTRIES)+1:2], for both lookup and update.
- JAL: taken=1; target = i_offset (pre-computed absolute); active=1; result = i_next_pc.
- JALR: taken=1; target = (i_rs1 + i_offset) & ~1; active=1; result = i_next_pc.
- BRANCH:
  - target = i_pc + i_offset; active=0; result=0.
  - Conditions: EQ, NE, LT, GE signed; LTU, GEU unsigned.
  - Undefined funct3: taken=0.
- Other opcodes: taken=0, target=0, active=0, mispredict = i_pred_taken, redirect = i_next_pc.
- Misalignment:
  - misaligned = taken && !C_EXT && target[1].
  - When set: o_misaligned=1, o_br_taken=0, o_active=0, o_mispredict=0, and no RAS update.
- Mispredict:
  - BRANCH: (pred_taken != taken) || (taken && pred_addr != target).
  - JAL/JALR: !pred_taken || pred_addr != target.
  - o_redirect_addr = taken ? target : i_next_pc.
- BHT update on accept of a BRANCH: taken → counter saturates up at 11; not taken → counter saturates down at 00. Arithmetic is 2-bit saturating, with no wrap.
- RAS update on accept of JAL/JALR (link register = x1 or x5):
  - rd link, rs1 not link (or JAL): push i_next_pc.
  - JALR, rs1 link, rd not link: pop.
  - Both link, rd != rs1: pop then push, i.e. replace the top.
  - Both link, rd == rs1: push.
- RAS boundaries:
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change; o_ras_valid stays 0.
- Same-cycle read/update: predict-port reads see pre-update state; updates become visible next cycle.
- i_flush:
  - o_valid=0 next cycle.
  - A same-cycle i_valid is not accepted: no BHT/RAS update.
  - Updates from already-accepted instructions are not rolled back.
- Reset mid-operation: everything returns to reset values immediately (asynchronous).

Decomposition:
- Shared package tiny_rv_pkg:
  - RV_JAL, RV_JALR, RV_BRANCH opcodes and RV_BR_* funct3 constants.
  - Link-register indices.
  - br_res_t struct (taken, addr, mispredict, redirect, misaligned, active, result).
- Sub-module tiny_rv_ras: push/pop/replace, circular pointer, saturating count, top/valid outputs.

Test Plan:
- BEQ with rs1=rs2=5, pc=0x100, off=0x20, pred_taken=0 → next cycle o_br_taken=1, o_br_addr=0x120, o_mispredict=1, o_redirect_addr=0x120; BHT[0] goes 01→10 and o_fetch_pred_taken(0x100)=1.
- BLT with rs1=0xFFFFFFFF, rs2=1, and BLTU with the same operands → BLT taken, BLTU not taken; four consecutive not-taken branches at one PC saturate the counter at 00.
- JAL rd=x1 ×5 with next_pc 0x4,0x8,…,0x14 and RAS_DEPTH=4 → o_ras_top=0x14, count=4; five JALR rs1=x1 rd=x0 pops → tops 0x10,0xC,0x8 then o_ras_valid=0, and the final pop changes nothing.
- JALR rs1=0x1001, off=0x2, C_EXT=0 → target 0x1002, o_misaligned=1, o_br_taken=0, o_active=0, RAS unchanged.
- Backpressure: i_ready=0 for 3 cycles with o_valid=1 → o_ready=0 and outputs stable; a second request is accepted in the cycle i_ready rises.
- i_flush asserted with i_valid=1 (BNE taken) → o_valid=0 next cycle and BHT unchanged; i_rst_n pulled low mid-stream → o_valid=0 at once and BHT back to 01.

Source files
------------

// File: rtl/tiny_rv_pkg.sv
// rtl/tiny_rv_pkg.sv - shared RISC-V control-transfer constants and branch result type
// Contents: major opcodes, branch funct3 codes, link-register indices,
// br_res_t resolved-branch record and the is_link helper.
package tiny_rv_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [6:0] RV_JAL    = 7'b1101111;
    localparam logic [6:0] RV_JALR   = 7'b1100111;
    localparam logic [6:0] RV_BRANCH = 7'b1100011;

    localparam logic [2:0] RV_BR_EQ  = 3'b000;
    localparam logic [2:0] RV_BR_NE  = 3'b001;
    localparam logic [2:0] RV_BR_LT  = 3'b100;
    localparam logic [2:0] RV_BR_GE  = 3'b101;
    localparam logic [2:0] RV_BR_LTU = 3'b110;
    localparam logic [2:0] RV_BR_GEU = 3'b111;

    // x1 (ra) and x5 (t0) are the architectural link registers for RAS hints
    localparam logic [4:0] RV_REG_RA = 5'd1;
    localparam logic [4:0] RV_REG_T0 = 5'd5;

    typedef struct packed {
        logic               taken;
        logic [RV_XLEN-1:0] addr;
        logic               mispredict;
        logic [RV_XLEN-1:0] redirect;
        logic               misaligned;
        logic               active;
        logic [RV_XLEN-1:0] result;
    } br_res_t;

    function automatic logic is_link(input logic [4:0] idx);
        return (idx == RV_REG_RA) || (idx == RV_REG_T0);
    endfunction

endpackage

// File: rtl/tiny_rv_br_unit_if.sv
// rtl/tiny_rv_br_unit_if.sv - request/result/predict bundle of the branch unit
// slave : branch unit view (drives o_* signals)
// master: execute/fetch view (drives i_* signals)
interface tiny_rv_br_unit_if #(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_next_pc;
    logic [XLEN-1:0] i_offset;
    logic [6:0]      i_opcode;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [4:0]      i_rd_idx;
    logic [4:0]      i_rs1_idx;
    logic            i_pred_taken;
    logic [XLEN-1:0] i_pred_addr;
    logic            o_valid;
    logic            i_ready;
    logic            o_br_taken;
    logic [XLEN-1:0] o_br_addr;
    logic            o_mispredict;
    logic [XLEN-1:0] o_redirect_addr;
    logic            o_misaligned;
    logic            o_active;
    logic [XLEN-1:0] o_result;
    logic [XLEN-1:0] i_fetch_pc;
    logic            o_fetch_pred_taken;
    logic [XLEN-1:0] o_ras_top;
    logic            o_ras_valid;

    modport slave (
        input  i_flush, i_valid, i_pc, i_next_pc, i_offset, i_opcode, i_funct3,
               i_rs1, i_rs2, i_rd_idx, i_rs1_idx, i_pred_taken, i_pred_addr,
               i_ready, i_fetch_pc,
        output o_ready, o_valid, o_br_taken, o_br_addr, o_mispredict,
               o_redirect_addr, o_misaligned, o_active, o_result,
               o_fetch_pred_taken, o_ras_top, o_ras_valid
    );

    modport master (
        output i_flush, i_valid, i_pc, i_next_pc, i_offset, i_opcode, i_funct3,
               i_rs1, i_rs2, i_rd_idx, i_rs1_idx, i_pred_taken, i_pred_addr,
               i_ready, i_fetch_pc,
        input  o_ready, o_valid, o_br_taken, o_br_addr, o_mispredict,
               o_redirect_addr, o_misaligned, o_active, o_result,
               o_fetch_pred_taken, o_ras_top, o_ras_valid
    );

endinterface

// File: rtl/tiny_rv_ras.sv
// rtl/tiny_rv_ras.sv - circular return-address stack with saturating occupancy
// Ports: clk/rst_n, push/pop/replace strobes (mutually exclusive), push_data,
// top (0 when empty), valid (stack not empty).
module tiny_rv_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            replace,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] entries [DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic            empty;
    logic            full;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - PW'(1);

    assign valid = !empty;
    assign top   = empty ? '0 : entries[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            ptr   <= '0;
            count <= '0;
        end else if (push || (replace && empty)) begin
            // replacing on an empty stack degenerates to a plain push;
            // a full stack overwrites its oldest slot and keeps count pinned
            ptr              <= ptr_inc;
            entries[ptr_inc] <= push_data;
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (replace) begin
            entries[ptr] <= push_data;
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/tiny_rv_br_unit.sv
// rtl/tiny_rv_br_unit.sv - pipelined JAL/JALR/branch resolver with BHT and RAS
// Ports: i_clk, i_rst_n (async active-low), br (tiny_rv_br_unit_if.slave):
// request handshake i_valid/o_ready, one-deep result register o_valid/i_ready,
// i_flush, combinational predict port i_fetch_pc -> o_fetch_pred_taken,
// o_ras_top/o_ras_valid.
module tiny_rv_br_unit
    import tiny_rv_pkg::*;
#(
    parameter int XLEN        = RV_XLEN,
    parameter int BHT_ENTRIES = 16,
    parameter int RAS_DEPTH   = 4,
    parameter int C_EXT       = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    tiny_rv_br_unit_if.slave br
);

    localparam int IDXW = $clog2(BHT_ENTRIES);

    logic            is_jal, is_jalr, is_br, is_jump;
    logic            cond_taken;
    logic            raw_taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;
    logic            misaligned;
    br_res_t         res;
    br_res_t         res_q;
    logic            res_valid;
    logic            accept;

    assign is_jal  = (br.i_opcode == RV_JAL);
    assign is_jalr = (br.i_opcode == RV_JALR);
    assign is_br   = (br.i_opcode == RV_BRANCH);
    assign is_jump = is_jal || is_jalr;

    always_comb begin
        cond_taken = 1'b0;
        case (br.i_funct3)
            RV_BR_EQ:  cond_taken = (br.i_rs1 == br.i_rs2);
            RV_BR_NE:  cond_taken = (br.i_rs1 != br.i_rs2);
            RV_BR_LT:  cond_taken = ($signed(br.i_rs1) <  $signed(br.i_rs2));
            RV_BR_GE:  cond_taken = ($signed(br.i_rs1) >= $signed(br.i_rs2));
            RV_BR_LTU: cond_taken = (br.i_rs1 <  br.i_rs2);
            RV_BR_GEU: cond_taken = (br.i_rs1 >= br.i_rs2);
            default:   cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        raw_taken = 1'b0;
        target    = '0;
        jalr_sum  = br.i_rs1 + br.i_offset;
        if (is_jal) begin
            raw_taken = 1'b1;
            target    = br.i_offset;
        end else if (is_jalr) begin
            raw_taken = 1'b1;
            target    = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_br) begin
            raw_taken = cond_taken;
            target    = br.i_pc + br.i_offset;
        end
    end

    assign misaligned = raw_taken && (C_EXT == 0) && target[1];

    // A misaligned transfer becomes an exception: nothing is taken, written
    // or redirected by this unit, the trap path owns the redirect.
    always_comb begin
        res            = '0;
        res.taken      = raw_taken && !misaligned;
        res.addr       = target;
        res.misaligned = misaligned;
        res.active     = is_jump && !misaligned;
        res.result     = is_jump ? br.i_next_pc : '0;
        res.redirect   = res.taken ? target : br.i_next_pc;
        if (misaligned) begin
            res.mispredict = 1'b0;
        end else if (is_br) begin
            res.mispredict = (br.i_pred_taken != raw_taken) ||
                             (raw_taken && (br.i_pred_addr != target));
        end else if (is_jump) begin
            res.mispredict = !br.i_pred_taken || (br.i_pred_addr != target);
        end else begin
            res.mispredict = br.i_pred_taken;
        end
    end

    assign br.o_ready = !res_valid || br.i_ready;
    assign accept     = br.i_valid && br.o_ready && !br.i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_valid <= 1'b0;
            res_q     <= '0;
        end else if (br.i_flush) begin
            res_valid <= 1'b0;
        end else if (br.o_ready) begin
            res_valid <= br.i_valid;
            if (br.i_valid) begin
                res_q <= res;
            end
        end
    end

    assign br.o_valid         = res_valid;
    assign br.o_br_taken      = res_q.taken;
    assign br.o_br_addr       = res_q.addr;
    assign br.o_mispredict    = res_q.mispredict;
    assign br.o_redirect_addr = res_q.redirect;
    assign br.o_misaligned    = res_q.misaligned;
    assign br.o_active        = res_q.active;
    assign br.o_result        = res_q.result;

    // Bimodal history table
    logic [1:0]      bht [BHT_ENTRIES];
    logic [IDXW-1:0] upd_idx;
    logic [IDXW-1:0] fetch_idx;
    logic            unused_fetch_bits;

    assign upd_idx   = br.i_pc[IDXW+1:2];
    assign fetch_idx = br.i_fetch_pc[IDXW+1:2];
    assign br.o_fetch_pred_taken = bht[fetch_idx][1];
    assign unused_fetch_bits = ^{br.i_fetch_pc[XLEN-1:IDXW+2], br.i_fetch_pc[1:0]};

    // Training follows the branch direction even when the target faults,
    // so the counter keeps tracking the condition outcome.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && is_br) begin
            if (cond_taken) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'b01;
                end
            end else if (bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
            end
        end
    end

    // Return-address stack hints
    logic rd_link, rs1_link, ras_ok;
    logic ras_push, ras_pop, ras_replace;

    assign rd_link  = is_link(br.i_rd_idx);
    assign rs1_link = is_link(br.i_rs1_idx);
    assign ras_ok   = accept && is_jump && !misaligned;

    assign ras_push    = ras_ok && rd_link &&
                         (is_jal || !rs1_link || (br.i_rd_idx == br.i_rs1_idx));
    assign ras_pop     = ras_ok && is_jalr && rs1_link && !rd_link;
    assign ras_replace = ras_ok && is_jalr && rs1_link && rd_link &&
                         (br.i_rd_idx != br.i_rs1_idx);

    tiny_rv_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .replace   (ras_replace),
        .push_data (br.i_next_pc),
        .top       (br.o_ras_top),
        .valid     (br.o_ras_valid)
    );

endmodule

// File: tb/tb_tiny_rv_br_unit.sv
// tb/tb_tiny_rv_br_unit.sv - directed self-checking bench for tiny_rv_br_unit
module tb_tiny_rv_br_unit;

    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tiny_rv_br_unit_if #(.XLEN(32)) bus ();

    tiny_rv_br_unit #(
        .XLEN        (32),
        .BHT_ENTRIES (16),
        .RAS_DEPTH   (4),
        .C_EXT       (0)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .br      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
        bus.i_fetch_pc = pc;
        #1;
        chk(tag, {31'b0, bus.o_fetch_pred_taken}, {31'b0, exp});
    endtask

    task automatic set_req(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] npc,
                           input logic [31:0] off, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [4:0] rd,
                           input logic [4:0] rs1i, input logic pt,
                           input logic [31:0] pa);
        bus.i_opcode     = op;
        bus.i_funct3     = f3;
        bus.i_pc         = pc;
        bus.i_next_pc    = npc;
        bus.i_offset     = off;
        bus.i_rs1        = rs1;
        bus.i_rs2        = rs2;
        bus.i_rd_idx     = rd;
        bus.i_rs1_idx    = rs1i;
        bus.i_pred_taken = pt;
        bus.i_pred_addr  = pa;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] npc,
                         input logic [31:0] off, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [4:0] rd,
                         input logic [4:0] rs1i, input logic pt,
                         input logic [31:0] pa);
        @(negedge clk);
        set_req(op, f3, pc, npc, off, rs1, rs2, rd, rs1i, pt, pa);
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_fetch_pc = 32'h0;
        set_req(7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);

        // reset state
        #12;
        chk("rst_o_valid", {31'b0, bus.o_valid}, 32'h0);
        chk("rst_o_ready", {31'b0, bus.o_ready}, 32'h1);
        chk("rst_ras_valid", {31'b0, bus.o_ras_valid}, 32'h0);
        chk("rst_ras_top", bus.o_ras_top, 32'h0);
        chk("rst_br_addr", bus.o_br_addr, 32'h0);
        chk_pred("rst_bht_0x100", 32'h100, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // BEQ taken, predicted not taken
        issue(OP_BR, 3'b000, 32'h100, 32'h104, 32'h20, 32'd5, 32'd5, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("beq_valid", {31'b0, bus.o_valid}, 32'h1);
        chk("beq_taken", {31'b0, bus.o_br_taken}, 32'h1);
        chk("beq_addr", bus.o_br_addr, 32'h120);
        chk("beq_mispred", {31'b0, bus.o_mispredict}, 32'h1);
        chk("beq_redirect", bus.o_redirect_addr, 32'h120);
        chk("beq_active", {31'b0, bus.o_active}, 32'h0);
        chk_pred("beq_bht_10", 32'h100, 1'b1);

        // signed vs unsigned compare on the same operands
        issue(OP_BR, 3'b100, 32'h204, 32'h208, 32'h10, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd0, 1'b1, 32'h214);
        chk("blt_taken", {31'b0, bus.o_br_taken}, 32'h1);
        chk("blt_addr", bus.o_br_addr, 32'h214);
        chk("blt_mispred", {31'b0, bus.o_mispredict}, 32'h0);
        issue(OP_BR, 3'b110, 32'h208, 32'h20C, 32'h10, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("bltu_taken", {31'b0, bus.o_br_taken}, 32'h0);
        chk("bltu_mispred", {31'b0, bus.o_mispredict}, 32'h0);
        chk("bltu_redirect", bus.o_redirect_addr, 32'h20C);

        // undefined funct3 resolves not taken
        issue(OP_BR, 3'b010, 32'h208, 32'h20C, 32'h10, 32'h3, 32'h3, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("bundef_taken", {31'b0, bus.o_br_taken}, 32'h0);

        // upward saturation: 10 -> 11 -> 11 -> 11, one not-taken -> 10
        for (int i = 0; i < 3; i++) begin
            issue(OP_BR, 3'b000, 32'h100, 32'h104, 32'h20, 32'd5, 32'd5, 5'd0, 5'd0, 1'b1, 32'h120);
        end
        issue(OP_BR, 3'b001, 32'h100, 32'h104, 32'h20, 32'd5, 32'd5, 5'd0, 5'd0, 1'b1, 32'h120);
        chk_pred("bht_sat_hi", 32'h100, 1'b1);

        // downward saturation: four not-taken pin at 00, then two taken reach 10
        for (int i = 0; i < 4; i++) begin
            issue(OP_BR, 3'b001, 32'h30C, 32'h310, 32'h40, 32'd3, 32'd3, 5'd0, 5'd0, 1'b0, 32'h0);
        end
        chk_pred("bht_sat_lo", 32'h30C, 1'b0);
        issue(OP_BR, 3'b000, 32'h30C, 32'h310, 32'h40, 32'd3, 32'd3, 5'd0, 5'd0, 1'b0, 32'h0);
        chk_pred("bht_lo_plus1", 32'h30C, 1'b0);
        issue(OP_BR, 3'b000, 32'h30C, 32'h310, 32'h40, 32'd3, 32'd3, 5'd0, 5'd0, 1'b0, 32'h0);
        chk_pred("bht_lo_plus2", 32'h30C, 1'b1);

        // RAS: five JAL x1 pushes into a depth-4 stack
        for (int k = 1; k <= 5; k++) begin
            issue(OP_JAL, 3'b000, 32'(4 * k - 4), 32'(4 * k), 32'h400, 32'h0, 32'h0,
                  5'd1, 5'd0, 1'b1, 32'h400);
            if (k == 1) begin
                chk("jal_taken", {31'b0, bus.o_br_taken}, 32'h1);
                chk("jal_addr", bus.o_br_addr, 32'h400);
                chk("jal_active", {31'b0, bus.o_active}, 32'h1);
                chk("jal_result", bus.o_result, 32'h4);
                chk("jal_mispred", {31'b0, bus.o_mispredict}, 32'h0);
            end
        end
        chk("ras_full_top", bus.o_ras_top, 32'h14);
        chk("ras_full_valid", {31'b0, bus.o_ras_valid}, 32'h1);

        // five JALR x0, x1 pops
        issue(OP_JALR, 3'b000, 32'h8FC, 32'h900, 32'h0, 32'h801, 32'h0, 5'd0, 5'd1, 1'b1, 32'h800);
        chk("jalr_addr", bus.o_br_addr, 32'h800);
        chk("jalr_mispred", {31'b0, bus.o_mispredict}, 32'h0);
        chk("jalr_result", bus.o_result, 32'h900);
        chk("pop1_top", bus.o_ras_top, 32'h10);
        issue(OP_JALR, 3'b000, 32'h8FC, 32'h900, 32'h0, 32'h801, 32'h0, 5'd0, 5'd1, 1'b1, 32'h800);
        chk("pop2_top", bus.o_ras_top, 32'hC);
        issue(OP_JALR, 3'b000, 32'h8FC, 32'h900, 32'h0, 32'h801, 32'h0, 5'd0, 5'd1, 1'b1, 32'h800);
        chk("pop3_top", bus.o_ras_top, 32'h8);
        issue(OP_JALR, 3'b000, 32'h8FC, 32'h900, 32'h0, 32'h801, 32'h0, 5'd0, 5'd1, 1'b1, 32'h800);
        chk("pop4_valid", {31'b0, bus.o_ras_valid}, 32'h0);
        issue(OP_JALR, 3'b000, 32'h8FC, 32'h900, 32'h0, 32'h801, 32'h0, 5'd0, 5'd1, 1'b1, 32'h800);
        chk("pop5_valid", {31'b0, bus.o_ras_valid}, 32'h0);
        chk("pop5_top", bus.o_ras_top, 32'h0);

        // misaligned JALR must not touch the RAS
        issue(OP_JAL, 3'b000, 32'h3C, 32'h40, 32'h400, 32'h0, 32'h0, 5'd1, 5'd0, 1'b1, 32'h400);
        chk("mis_pre_top", bus.o_ras_top, 32'h40);
        issue(OP_JALR, 3'b000, 32'h4C, 32'h50, 32'h2, 32'h1001, 32'h0, 5'd1, 5'd0, 1'b0, 32'h0);
        chk("mis_flag", {31'b0, bus.o_misaligned}, 32'h1);
        chk("mis_taken", {31'b0, bus.o_br_taken}, 32'h0);
        chk("mis_active", {31'b0, bus.o_active}, 32'h0);
        chk("mis_mispred", {31'b0, bus.o_mispredict}, 32'h0);
        chk("mis_addr", bus.o_br_addr, 32'h1002);
        chk("mis_ras_top", bus.o_ras_top, 32'h40);

        // backpressure: non-branch opcode result held for three stalled cycles
        issue(OP_ALU, 3'b000, 32'h500, 32'h504, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0);
        bus.i_ready = 1'b0;
        #1;
        chk("bp_valid", {31'b0, bus.o_valid}, 32'h1);
        chk("bp_ready", {31'b0, bus.o_ready}, 32'h0);
        chk("alu_taken", {31'b0, bus.o_br_taken}, 32'h0);
        chk("alu_addr", bus.o_br_addr, 32'h0);
        chk("alu_mispred", {31'b0, bus.o_mispredict}, 32'h1);
        chk("alu_redirect", bus.o_redirect_addr, 32'h504);
        @(negedge clk);
        set_req(OP_JAL, 3'b000, 32'h600, 32'h604, 32'h700, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        bus.i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("bp_stall_ready", {31'b0, bus.o_ready}, 32'h0);
            chk("bp_stall_redirect", bus.o_redirect_addr, 32'h504);
        end
        @(negedge clk);
        bus.i_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, bus.o_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        chk("bp_second_valid", {31'b0, bus.o_valid}, 32'h1);
        chk("bp_second_addr", bus.o_br_addr, 32'h700);
        chk("bp_second_result", bus.o_result, 32'h604);
        chk("bp_second_mispred", {31'b0, bus.o_mispredict}, 32'h1);

        // flush drops staged result and the same-cycle taken BNE
        @(negedge clk);
        set_req(OP_BR, 3'b001, 32'h314, 32'h318, 32'h8, 32'h1, 32'h2, 5'd0, 5'd0, 1'b0, 32'h0);
        bus.i_valid = 1'b1;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        chk("flush_valid", {31'b0, bus.o_valid}, 32'h0);
        chk_pred("flush_bht", 32'h314, 1'b0);

        // asynchronous reset mid-stream
        issue(OP_BR, 3'b000, 32'h314, 32'h318, 32'h8, 32'h7, 32'h7, 5'd0, 5'd0, 1'b1, 32'h31C);
        chk_pred("pre_rst_bht", 32'h314, 1'b1);
        chk("pre_rst_valid", {31'b0, bus.o_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, bus.o_valid}, 32'h0);
        chk("async_rst_ras", {31'b0, bus.o_ras_valid}, 32'h0);
        chk_pred("async_rst_bht", 32'h314, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
